// File: rtl/mem_responder_if.sv
// Request/response bundle between the processor's memory strobes and the responder.
// The requester drives the strobes, address and write data; the responder returns data and a ready pulse.
interface mem_responder_if;
  logic       MemRead;
  logic       MemWrite;
  logic [7:0] Addr;
  logic [7:0] WriteData;
  logic [7:0] ReadData;
  logic       MemReady;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, MemReady
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, MemReady
  );
endinterface

// File: rtl/mem_responder.sv
// Wait-state memory responder: a 256x8 array plus an LED register and a synchronized switch port.
// Each request completes with a one-cycle MemReady pulse after WAIT_CYCLES extra cycles.
module mem_responder #(
  parameter int         WAIT_CYCLES = 1,
  parameter logic [7:0] LED_ADDR    = 8'hFE,
  parameter logic [7:0] SW_ADDR     = 8'hFF
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus,
  output logic [7:0]     led_out,
  input  logic [7:0]     sw_in,
  output logic           err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  logic [1:0] state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       wr_lat_reg;
  logic [7:0] addr_lat_reg, wdata_lat_reg;
  logic [7:0] sw_meta_reg, sw_sync_reg;
  logic [7:0] rdata_reg, led_reg;
  logic       err_reg;
  logic [7:0] mem_array [0:255];

  logic       accept, enter_resp, op_wr;
  logic [7:0] op_addr, op_wdata;

  always_comb begin
    accept     = (state_reg == IDLE) && (bus.MemRead || bus.MemWrite);
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next   = WAIT_INIT;
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg <= 3'd1) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    enter_resp = (state_next == RESP) && (state_reg != RESP);
    // With zero wait states the commit edge is also the acceptance edge, so use the live bus.
    op_wr    = (state_reg == IDLE) ? bus.MemWrite  : wr_lat_reg;
    op_addr  = (state_reg == IDLE) ? bus.Addr      : addr_lat_reg;
    op_wdata = (state_reg == IDLE) ? bus.WriteData : wdata_lat_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      wr_lat_reg    <= 1'b0;
      addr_lat_reg  <= '0;
      wdata_lat_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        wr_lat_reg    <= bus.MemWrite;
        addr_lat_reg  <= bus.Addr;
        wdata_lat_reg <= bus.WriteData;
        if (bus.MemRead && bus.MemWrite) err_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= sw_in;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_reg <= '0;
    end else if (enter_resp && op_wr && (op_addr == LED_ADDR)) begin
      led_reg <= op_wdata;
    end
  end

  // No reset on the array itself; reset only blocks a commit that would land on the same edge.
  always_ff @(posedge clock) begin
    if (!reset && enter_resp && op_wr && (op_addr != LED_ADDR) && (op_addr != SW_ADDR)) begin
      mem_array[op_addr] <= op_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (enter_resp && !op_wr) begin
      if (op_addr == LED_ADDR)     rdata_reg <= led_reg;
      else if (op_addr == SW_ADDR) rdata_reg <= sw_sync_reg;
      else                         rdata_reg <= mem_array[op_addr];
    end
  end

  assign bus.ReadData = rdata_reg;
  assign bus.MemReady = (state_reg == RESP);
  assign led_out      = led_reg;
  assign err          = err_reg;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 1 and 3 wait states) driven by a shared task,
// with read results predicted into a scoreboard queue at issue time and compared on MemReady.
module tb_mem_responder;
  logic       clock = 1'b0;
  logic [2:0] rst;
  logic [2:0] mr, mw, rdy, errv;
  logic [7:0] ad [3];
  logic [7:0] wd [3];
  logic [7:0] rdata [3];
  logic [7:0] led [3];
  logic [7:0] sw;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] d;
    logic [7:0] v;
  } sb_t;
  sb_t sb_q[$];

  logic [7:0] mem_model [3][256];
  logic [7:0] led_model [3];
  logic [7:0] last_rd [3];
  logic       in_resp [3];
  int         wait_of [3];

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_responder_if bus_i ();
    assign bus_i.MemRead   = mr[gi];
    assign bus_i.MemWrite  = mw[gi];
    assign bus_i.Addr      = ad[gi];
    assign bus_i.WriteData = wd[gi];
    assign rdata[gi]       = bus_i.ReadData;
    assign rdy[gi]         = bus_i.MemReady;

    mem_responder #(
      .WAIT_CYCLES((gi == 0) ? 0 : (gi == 1) ? 1 : 3),
      .LED_ADDR   (8'hFE),
      .SW_ADDR    (8'hFF)
    ) u_dut (
      .clock  (clock),
      .reset  (rst[gi]),
      .bus    (bus_i),
      .led_out(led[gi]),
      .sw_in  (sw),
      .err    (errv[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Caller is at a negedge; d's FSM is in IDLE or (if in_resp) in RESP.
  task automatic issue(input int d, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] wdat);
    int cnt;
    sb_t e;
    mr[d] = rd; mw[d] = wr; ad[d] = a; wd[d] = wdat;
    if (rd && !wr) begin
      e.d = 2'(d);
      if (a == 8'hFE)      e.v = led_model[d];
      else if (a == 8'hFF) e.v = sw;
      else                 e.v = mem_model[d][a];
      sb_q.push_back(e);
    end
    if (in_resp[d]) @(posedge clock);
    @(posedge clock);
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (!rdy[d] && cnt <= 20);
    mr[d] = 1'b0; mw[d] = 1'b0;
    in_resp[d] = 1'b1;
    chk($sformatf("latency d%0d a%0h", d, a), cnt, wait_of[d] + 1);
    if (wr) begin
      if (a == 8'hFE)      led_model[d] = wdat;
      else if (a != 8'hFF) mem_model[d][a] = wdat;
      chk($sformatf("rdata_hold_on_write d%0d", d), rdata[d], last_rd[d]);
    end else if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("rdata d%0d a%0h", e.d, a), rdata[d], e.v);
      last_rd[d] = e.v;
    end
    chk($sformatf("led d%0d", d), led[d], led_model[d]);
    $display("txn d%0d rd=%0b wr=%0b addr=%0h wdata=%0h rdata=%0h lat=%0d",
             d, rd, wr, a, wdat, rdata[d], cnt);
  endtask

  task automatic idle_cycle(input int d);
    @(negedge clock);
    chk($sformatf("ready_pulse d%0d", d), rdy[d], 0);
    in_resp[d] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int d);
    chk($sformatf("rst_rdata d%0d", d), rdata[d], 0);
    chk($sformatf("rst_ready d%0d", d), rdy[d], 0);
    chk($sformatf("rst_led d%0d", d), led[d], 0);
    chk($sformatf("rst_err d%0d", d), errv[d], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_of[0] = 0; wait_of[1] = 1; wait_of[2] = 3;
    for (int d = 0; d < 3; d++) begin
      mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = '0; wd[d] = '0;
      led_model[d] = '0; last_rd[d] = '0; in_resp[d] = 1'b0;
    end
    sw  = '0;
    rst = 3'b111;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 3; d++) check_reset_outputs(d);
    rst = 3'b000;
    @(negedge clock);

    // One wait state: write then read back, value held afterwards.
    issue(1, 1'b0, 1'b1, 8'h10, 8'h5A); idle_cycle(1);
    issue(1, 1'b1, 1'b0, 8'h10, 8'h00); idle_cycle(1);
    chk("rdata_held d1", rdata[1], 8'h5A);

    // Zero wait states: preload, then back-to-back reads.
    issue(0, 1'b0, 1'b1, 8'h10, 8'h5A); idle_cycle(0);
    issue(0, 1'b0, 1'b1, 8'h11, 8'h3C); idle_cycle(0);
    issue(0, 1'b1, 1'b0, 8'h10, 8'h00);
    issue(0, 1'b1, 1'b0, 8'h11, 8'h00); idle_cycle(0);

    // LED register write and readback.
    issue(1, 1'b0, 1'b1, 8'hFE, 8'hA5); idle_cycle(1);
    issue(1, 1'b1, 1'b0, 8'hFE, 8'h00); idle_cycle(1);

    // Switch input through the synchronizer; writes to it are dropped.
    sw = 8'h81;
    repeat (3) @(negedge clock);
    issue(1, 1'b1, 1'b0, 8'hFF, 8'h00); idle_cycle(1);
    issue(1, 1'b0, 1'b1, 8'hFF, 8'h00); idle_cycle(1);
    issue(1, 1'b1, 1'b0, 8'hFF, 8'h00); idle_cycle(1);

    // Simultaneous read and write: write wins, err is sticky.
    issue(1, 1'b1, 1'b1, 8'h20, 8'h77); idle_cycle(1);
    chk("err_set d1", errv[1], 1);
    chk("array20 d1", g_dut[1].u_dut.mem_array[8'h20], 8'h77);
    issue(1, 1'b1, 1'b0, 8'h20, 8'h00); idle_cycle(1);
    chk("err_sticky d1", errv[1], 1);
    chk("err_other d0", errv[0], 0);
    rst[1] = 1'b1;
    @(negedge clock);
    check_reset_outputs(1);
    rst[1] = 1'b0;
    led_model[1] = '0; last_rd[1] = '0;
    @(negedge clock);

    // Three wait states: establish old value, then abort a write with reset.
    issue(2, 1'b0, 1'b1, 8'h30, 8'h11); idle_cycle(2);
    issue(2, 1'b1, 1'b0, 8'h30, 8'h00); idle_cycle(2);
    mw[2] = 1'b1; ad[2] = 8'h30; wd[2] = 8'hEE;
    @(posedge clock);
    @(negedge clock);
    chk("abort_wait1_ready", rdy[2], 0);
    @(negedge clock);
    rst[2] = 1'b1; mw[2] = 1'b0;
    @(negedge clock);
    check_reset_outputs(2);
    @(negedge clock);
    chk("abort_hold_ready", rdy[2], 0);
    rst[2] = 1'b0;
    last_rd[2] = '0;
    @(negedge clock);
    chk("abort_no_ready", rdy[2], 0);
    chk("abort_array30", g_dut[2].u_dut.mem_array[8'h30], 8'h11);
    issue(2, 1'b1, 1'b0, 8'h30, 8'h00); idle_cycle(2);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
